// File: rtl/mmio_periph.sv
// Memory-mapped I/O peripheral: synchronized switches, debounced push-buttons with
// sticky press events, an LED register and a hex / signed-decimal seven-segment display.
module mmio_periph #(
    parameter logic [31:0] BASE            = 32'hC000_0000,
    parameter int          SW_W            = 10,
    parameter int          LED_W           = 10,
    parameter int          NUM_PB          = 1,
    parameter int          PB_ACTIVE_LOW   = 1,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          NUM_DISP        = 5
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic [SW_W-1:0]       switches,
    input  logic [NUM_PB-1:0]     pb,
    output logic [LED_W-1:0]      leds,
    output logic [7*NUM_DISP-1:0] disp
);
    localparam int         CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [2:0] REG_SW    = 3'd0;
    localparam logic [2:0] REG_PB    = 3'd1;
    localparam logic [2:0] REG_LED   = 3'd2;
    localparam logic [2:0] REG_DVAL  = 3'd3;
    localparam logic [2:0] REG_DCTRL = 3'd4;
    localparam logic [2:0] REG_DSTAT = 3'd5;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {DB_REL, DB_PRESS_WAIT, DB_PRS, DB_REL_WAIT} db_state_e;
    typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT, CV_COMMIT} cv_state_e;

    logic [SW_W-1:0]       sw_s1_q, sw_s2_q;
    logic [NUM_PB-1:0]     pb_s1_q, pb_s2_q, pb_pressed, pb_level, evt_q, evt_d;
    db_state_e             db_state_q [NUM_PB];
    db_state_e             db_state_d [NUM_PB];
    logic [CNT_W-1:0]      db_cnt_q [NUM_PB];
    logic [CNT_W-1:0]      db_cnt_d [NUM_PB];
    logic [LED_W-1:0]      led_q, led_d;
    logic [31:0]           dval_q, dval_d;
    logic [1:0]            dctrl_q, dctrl_d;
    cv_state_e             cv_state_q, cv_state_d;
    logic [4:0]            shift_cnt_q, shift_cnt_d;
    logic [31:0]           bin_q, bin_d;
    logic [39:0]           bcd_q, bcd_d, bcd_adj;
    logic                  neg_q, neg_d;
    logic [7*NUM_DISP-1:0] fmt_q, fmt_d, dec_fmt;
    logic [71:0]           dd_shift;
    logic [32:0]           dval_abs;
    logic [7:0]            pb_lvl8, evt8;
    logic [2:0]            reg_sel;
    logic                  hit, wr_en, busy, conv_start, conv_stop, ovf, lead;
    int                    avail;
    logic                  unused_bits;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] on;  // active-high gfedcba
        case (v)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    assign pb_pressed  = (PB_ACTIVE_LOW != 0) ? ~pb : pb;
    assign busy        = (cv_state_q != CV_IDLE);
    assign leds        = led_q;
    assign disp        = dctrl_q[1] ? fmt_q : '1;
    assign unused_bits = ^{addr[7:5], addr[1:0], dval_abs[32]};

    // Bus: a write lands on the clock edge where we=1 and the address hits;
    // reads are combinational and never change state.
    always_comb begin
        hit     = (addr[31:8] == BASE[31:8]);
        reg_sel = addr[4:2];
        wr_en   = we && hit;
        led_d   = led_q;
        dval_d  = dval_q;
        dctrl_d = dctrl_q;
        if (wr_en) begin
            case (reg_sel)
                REG_LED:   led_d   = wdata[LED_W-1:0];
                REG_DVAL:  dval_d  = wdata;
                REG_DCTRL: dctrl_d = wdata[1:0];
                default:   ;
            endcase
        end
        conv_start = wr_en && (reg_sel == REG_DVAL || reg_sel == REG_DCTRL) && dctrl_d[0];
        conv_stop  = wr_en && (reg_sel == REG_DVAL || reg_sel == REG_DCTRL) && !dctrl_d[0];
    end

    always_comb begin
        for (int i = 0; i < NUM_PB; i++) begin
            db_state_d[i] = db_state_q[i];
            db_cnt_d[i]   = db_cnt_q[i];
            case (db_state_q[i])
                DB_REL: if (pb_s2_q[i]) begin
                    db_state_d[i] = DB_PRESS_WAIT;
                    db_cnt_d[i]   = CNT_W'(1);
                end
                DB_PRESS_WAIT: if (!pb_s2_q[i]) begin
                    db_state_d[i] = DB_REL;
                    db_cnt_d[i]   = '0;
                end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_state_d[i] = DB_PRS;
                    db_cnt_d[i]   = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
                DB_PRS: if (!pb_s2_q[i]) begin
                    db_state_d[i] = DB_REL_WAIT;
                    db_cnt_d[i]   = CNT_W'(1);
                end
                default: if (pb_s2_q[i]) begin
                    db_state_d[i] = DB_PRS;
                    db_cnt_d[i]   = '0;
                end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_state_d[i] = DB_REL;
                    db_cnt_d[i]   = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            endcase
            pb_level[i] = (db_state_q[i] == DB_PRS) || (db_state_q[i] == DB_REL_WAIT);
            // A press entering PRS wins over a same-cycle clear.
            evt_d[i] = ((db_state_d[i] == DB_PRS) && (db_state_q[i] != DB_PRS)) ||
                       (evt_q[i] && !(wr_en && reg_sel == REG_PB && wdata[8+i]));
        end
    end

    always_comb begin
        avail   = neg_q ? NUM_DISP - 1 : NUM_DISP;
        ovf     = (bcd_q >> (4 * avail)) != '0;
        lead    = 1'b1;
        dec_fmt = '1;
        for (int k = NUM_DISP - 1; k >= 0; k--) begin
            if (neg_q && k == NUM_DISP - 1) begin
                dec_fmt[7*k +: 7] = SEG_MINUS;
            end else begin
                if (bcd_q[4*k +: 4] != 4'd0 || k == 0) lead = 1'b0;
                dec_fmt[7*k +: 7] = lead ? SEG_BLANK : seg7(bcd_q[4*k +: 4]);
            end
            if (ovf) dec_fmt[7*k +: 7] = SEG_MINUS;
        end
    end

    always_comb begin
        cv_state_d  = cv_state_q;
        shift_cnt_d = shift_cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        neg_d       = neg_q;
        fmt_d       = fmt_q;
        // 33-bit magnitude so that -2^31 becomes +2^31 rather than wrapping.
        dval_abs    = dval_q[31] ? 33'd0 - {dval_q[31], dval_q} : {1'b0, dval_q};
        bcd_adj     = bcd_q;
        for (int k = 0; k < 10; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        dd_shift = {bcd_adj, bin_q} << 1;
        case (cv_state_q)
            CV_LOAD: begin
                neg_d       = dval_q[31];
                bin_d       = dval_abs[31:0];
                bcd_d       = '0;
                shift_cnt_d = '0;
                cv_state_d  = CV_SHIFT;
            end
            CV_SHIFT: begin
                {bcd_d, bin_d} = dd_shift;
                shift_cnt_d    = shift_cnt_q + 5'd1;
                if (shift_cnt_q == 5'd31) cv_state_d = CV_COMMIT;
            end
            CV_COMMIT: begin
                fmt_d      = dec_fmt;
                cv_state_d = CV_IDLE;
            end
            default: ;
        endcase
        if (conv_start) cv_state_d = CV_LOAD;
        else if (conv_stop) cv_state_d = CV_IDLE;
        if (!dctrl_d[0]) begin
            for (int k = 0; k < NUM_DISP; k++) fmt_d[7*k +: 7] = seg7(dval_d[4*k +: 4]);
        end else if (conv_start) begin
            fmt_d = fmt_q;
        end
    end

    always_comb begin
        pb_lvl8               = '0;
        evt8                  = '0;
        pb_lvl8[NUM_PB-1:0]   = pb_level;
        evt8[NUM_PB-1:0]      = evt_q;
        rdata                 = '0;
        if (hit) begin
            case (reg_sel)
                REG_SW:    rdata = 32'(sw_s2_q);
                REG_PB:    rdata = {16'd0, evt8, pb_lvl8};
                REG_LED:   rdata = 32'(led_q);
                REG_DVAL:  rdata = dval_q;
                REG_DCTRL: rdata = {30'd0, dctrl_q};
                REG_DSTAT: rdata = {31'd0, busy};
                default:   rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            pb_s1_q     <= '0;
            pb_s2_q     <= '0;
            evt_q       <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                db_state_q[i] <= DB_REL;
                db_cnt_q[i]   <= '0;
            end
            led_q       <= '0;
            dval_q      <= '0;
            dctrl_q     <= '0;
            cv_state_q  <= CV_IDLE;
            shift_cnt_q <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            fmt_q       <= '1;
        end else begin
            sw_s1_q     <= switches;
            sw_s2_q     <= sw_s1_q;
            pb_s1_q     <= pb_pressed;
            pb_s2_q     <= pb_s1_q;
            evt_q       <= evt_d;
            for (int i = 0; i < NUM_PB; i++) begin
                db_state_q[i] <= db_state_d[i];
                db_cnt_q[i]   <= db_cnt_d[i];
            end
            led_q       <= led_d;
            dval_q      <= dval_d;
            dctrl_q     <= dctrl_d;
            cv_state_q  <= cv_state_d;
            shift_cnt_q <= shift_cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            neg_q       <= neg_d;
            fmt_q       <= fmt_d;
        end
    end
endmodule

// File: doc/mmio_periph.md
MMIO_PERIPH -- requirements
Module: mmio_periph

Interface
REQ-001 Parameter BASE, default 32'hC000_0000: peripheral base address; the block decodes addr[31:8] == BASE[31:8].
REQ-002 Parameter SW_W, default 10: switch input width, 1..32.
REQ-003 Parameter LED_W, default 10: LED output width, 1..32.
REQ-004 Parameter NUM_PB, default 1: push-button count, 1..8.
REQ-005 Parameter PB_ACTIVE_LOW, default 1: 1 means a pressed button reads 0 at the pin.
REQ-006 Parameter DEBOUNCE_CYCLES, default 500000: number of stable cycles required to accept a level change, minimum 2.
REQ-007 Parameter NUM_DISP, default 5: number of seven-segment digits, 2..8.
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 nreset  in  1  asynchronous, active-low reset.
REQ-010 we  in  1  bus write strobe; a write takes effect at the clk edge when we=1 and the address decodes.
REQ-011 addr  in  32  byte address; addr[4:2] selects the register.
REQ-012 wdata  in  32  write data.
REQ-013 rdata  out  32  combinational read data for addr; 0 when the address does not decode or the register is unmapped.
REQ-014 switches  in  SW_W  asynchronous switch inputs.
REQ-015 pb  in  NUM_PB  asynchronous push-button inputs.
REQ-016 leds  out  LED_W  LED drive, active-high.
REQ-017 disp  out  7*NUM_DISP  active-low segments; digit i is disp[7i+6:7i] with bit6=g through bit0=a; digit 0 is the rightmost.

Function
REQ-018 Register map at offset addr[4:2]:
- 0 SW (RO): synchronized switches, zero-extended to 32 bits.
- 1 PB (RW): bits[7:0] hold the debounced level, 1=pressed; bits[15:8] hold sticky press events.
- 2 LED (RW): leds = reg[LED_W-1:0].
- 3 DVAL (RW): signed 32-bit display value.
- 4 DCTRL (RW): bit0 is mode (0=hex, 1=signed decimal); bit1 is enable (0 = all digits blank).
- 5 DSTAT (RO): bit0 is busy.
REQ-019 Switch and pb inputs SHALL pass through a 2-flop synchronizer, so SW reflects a switch change 2 cycles later.
REQ-020 Each button SHALL have a debounce FSM with states REL, PRESS_WAIT, PRS and REL_WAIT:
- REL -> PRESS_WAIT on a synced press.
- PRESS_WAIT -> PRS after DEBOUNCE_CYCLES consecutive pressed cycles; any released sample returns it to REL and resets the counter.
- PRS -> REL_WAIT and REL_WAIT -> REL follow the same rule in reverse.
REQ-021 Entering PRS SHALL set that button's event bit; writing PB with bit[8+i]=1 clears event bit i.
REQ-022 A set and a clear of the same event bit in the same cycle SHALL leave the bit set.
REQ-023 A read SHALL NOT clear any state.
REQ-024 Hex mode: digit i shows DVAL[4i+3:4i] using glyphs 0-F with no blanking; disp updates at the edge after the DVAL or DCTRL write; busy stays 0.
REQ-025 Decimal mode: a write to DVAL or DCTRL starts a conversion.
- The conversion takes the absolute value of DVAL, then runs a double-dabble FSM (IDLE -> LOAD -> SHIFT×32 -> COMMIT -> IDLE).
- busy=1 for exactly 34 cycles after the write edge.
- disp updates only at COMMIT; before that it holds its previous value.
REQ-026 A DVAL or DCTRL write while busy SHALL restart the conversion from LOAD using the new value.
REQ-027 Decimal formatting:
- Non-negative values use all NUM_DISP digits.
- Negative values put '-' (7'b0111111) on digit NUM_DISP-1 and the magnitude on the remaining digits.
- Leading zeros are blank (7'b1111111); digit 0 always shows a digit.
REQ-028 Overflow: if the magnitude does not fit the available digits, all digits SHALL show '-'.
REQ-029 The absolute value SHALL be computed in 33 bits so that 32'h8000_0000 is handled correctly and reports overflow.
REQ-030 The enable bit is applied combinationally after the formatting; a mode change starts a new conversion.

Reset
REQ-031 While nreset=0 (asynchronous):
- leds = 0, LED = 0, DVAL = 0, DCTRL = 0.
- Event bits = 0; all debounce FSMs in REL with counters at 0; synchronizers cleared.
- Converter in IDLE with busy = 0; disp = all 1s (blank).
REQ-032 Reset asserted mid-conversion SHALL abort the conversion with no COMMIT; after release the block stays idle until the next write.

Verification
REQ-033 Use DEBOUNCE_CYCLES=4 and NUM_DISP=5. Drive switches=10'h009, wait 2 cycles, then read BASE+0 -> 32'h9. Drive switches=10'h031 -> SW reads 32'h31 after 2 cycles.
REQ-034 Press pb (0) for 3 cycles -> no event. Press for 10 cycles -> PB bit8=1 and bit0=1. Write 32'h100 -> bit8=0. A clear in the same cycle as a new press -> bit8 stays 1.
REQ-035 Write DCTRL=3 and DVAL=58 -> busy=1 for exactly 34 cycles, then digits[4:0] are blank,blank,blank,'5','8'. Write DVAL=-39 -> '-',blank,blank,'3','9'.
REQ-036 In decimal mode, DVAL=-10000 -> all five digits '-'. DVAL=99999 -> '9'×5. DVAL=32'h8000_0000 -> all '-'. DVAL=0 -> four blanks then '0'.
REQ-037 Write DCTRL=2 and DVAL=32'h000A_BCDE -> next cycle digits show A,b,C,d,E with busy=0. Write DCTRL=0 -> all digits blank.
REQ-038 Write DVAL=58, then write DVAL=-39 10 cycles later -> busy stays 1 for 34 cycles after the second write and the '-39' pattern is committed; '58' never appears. nreset pulsed mid-conversion -> disp blank and busy=0.
